decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage for the RV32I core, placed between the fetch buffer and the execute stage.
- Decodes the full RV32I base integer set: ALU reg/imm, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
- Generates the ALU function, register indices, sign-extended immediate per instruction format, control flags and an illegal-instruction flag.
- Provides valid/ready handshaking on both sides, plus stall and flush support.

Parameters:
- XLEN, 32: datapath and immediate width; must be at least 32; immediates sign-extend to XLEN.
- PC_WIDTH, 32: width of the program counter carried alongside the instruction.
- ILLEGAL_AS_NOP, 0: 1 forces reg_write, is_load, is_store, is_branch and is_jump to 0 on illegal instructions; 0 leaves them as decoded.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard the held and incoming instruction
- in_valid  in  1  instruction/pc valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_WIDTH  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  PC_WIDTH  registered pc
- alu_funct  out  ALU_FUNCT_WIDTH  ALU operation code from the team's ALU function defines
- rs1, rs2, rd  out  5 each  register indices
- immed  out  XLEN  decoded immediate
- alu_src_imm  out  1  ALU operand B is immed
- reg_write  out  1  writes rd
- is_load, is_store, is_branch, is_jump  out  1 each  instruction class
- illegal  out  1  unsupported opcode or funct combination

Behaviour:
- The clock is clk. Reset is rst: synchronous and active-high.
- Reset: out_valid=0, every other output register=0 (alu_funct=ALU_FUNCT_ADD encoding).
- Latency: 1 cycle. A bundle accepted at edge N is visible with out_valid=1 after edge N.
- in_ready = !out_valid || out_ready, combinational. The upstream side must not depend on in_ready combinationally through in_valid.
- Accept when in_valid && in_ready: load all output registers and set out_valid=1.
- Consume when out_valid && out_ready with no new accept: out_valid=0 next cycle.
- Stall (out_valid && !out_ready): all outputs hold stable, bit for bit.
- flush (highest priority after rst): out_valid=0 next cycle and the incoming instruction is dropped. Data registers may hold stale values.
- rst asserted mid-stall or in the same cycle as flush/accept: the reset state wins.
- ALU function:
  - ALU_REG: funct3/funct7 map to the ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND codes.
  - funct7 must be 0x00, or 0x20 for ADD→SUB and SRL→SRA only; any other funct7 sets illegal=1.
  - ALU_IMM: funct7 is ignored except for SLLI (must be 0x00) and SRLI/SRAI (0x00 or 0x20). There is no SUBI; funct3=000 is always ADD.
  - All other opcodes use ALU_FUNCT_ADD.
- Immediates, all sign-extended from bit 31 to XLEN:
  - I-type: inst[31:20].
  - Shift-imm: zero-extended inst[24:20].
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type: immed=0.
- Flags:
  - alu_src_imm=1 for all classes except ALU_REG and BRANCH.
  - reg_write=0 for STORE, BRANCH, illegal (when ILLEGAL_AS_NOP=1), and rd==0.
  - is_jump is set for JAL and JALR. JALR requires funct3=000.
  - BRANCH funct3 010 and 011 are illegal.
- rs1, rs2, rd are always raw fields inst[19:15], inst[24:20], inst[11:7], regardless of format.
- Unknown opcode: illegal=1 and alu_funct=ADD.

Test Plan:
- Reset, then in_valid=1 with 0xFFF10093 (addi x1,x2,-1) → next cycle out_valid=1, rs1=2, rd=1, immed=0xFFFFFFFF, alu_funct=ADD, alu_src_imm=1, reg_write=1.
- 0x0051A423 (sw x5,8(x3)), then 0x123453B7 (lui x7,0x12345) back-to-back with out_ready=1 → first bundle: immed=8, rs1=3, rs2=5, is_store=1, reg_write=0. Second bundle: immed=0x12345000, rd=7.
- 0xFE208EE3 (beq x1,x2,-4) → immed=0xFFFFFFFC, is_branch=1, alu_src_imm=0. 0x40325213 (srai x4,x4,3) → alu_funct=SRA, immed=3.
- 0x02208033 (funct7=0x01 on add) and opcode 0x7F → illegal=1. With ILLEGAL_AS_NOP=1, reg_write=0.
- out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and outputs unchanged throughout. Releasing out_ready gives exactly one accept per cycle with no loss or duplication.
- flush asserted while stalled, then rst asserted while in_valid=1 → out_valid=0 on the next cycle in both cases, and the dropped instructions never appear.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side (in_*) and execute-side (out_*) signals of decode_stage; master = neighbours, slave = stage
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_WIDTH = 32,
  parameter int ALU_FUNCT_WIDTH = 4
);
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic out_valid;
  logic out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [XLEN-1:0] immed;
  logic alu_src_imm;
  logic reg_write;
  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_jump;
  logic illegal;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input in_ready, out_valid, out_pc, alu_funct, rs1, rs2, rd, immed,
    input alu_src_imm, reg_write, is_load, is_store, is_branch, is_jump, illegal
  );
  modport slave (
    input in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, alu_funct, rs1, rs2, rd, immed,
    output alu_src_imm, reg_write, is_load, is_store, is_branch, is_jump, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage; ports clk, rst (sync high), flush, bus (decode_stage_if.slave: in valid/ready/instr/pc, out valid/ready/pc + decoded fields)
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_WIDTH = 32,
  parameter int ILLEGAL_AS_NOP = 0,
  parameter int ALU_FUNCT_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  input logic flush,
  decode_stage_if.slave bus
);
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD = 0, ALU_SUB = 1, ALU_SLL = 2, ALU_SLT = 3, ALU_SLTU = 4,
    ALU_XOR = 5, ALU_SRL = 6, ALU_SRA = 7, ALU_OR = 8, ALU_AND = 9;
  localparam logic [6:0] OP_REG = 7'h33, OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23,
    OP_BRANCH = 7'h63, OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  logic [31:0] i, imm32;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic alt, d_ill, d_wr, d_load, d_store, d_branch, d_jump, d_src, nop, accept;
  logic [ALU_FUNCT_WIDTH-1:0] f3_alu, d_alu;
  assign i = bus.in_instr;
  assign op = i[6:0];
  assign f3 = i[14:12];
  assign f7 = i[31:25];
  // funct7[5] selects SUB/SRA for register ops but only SRAI among immediates
  assign alt = f7[5] && (op == OP_REG || f3 == 3'b101);
  assign f3_alu = f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
                  f3 == 3'b001 ? ALU_SLL :
                  f3 == 3'b010 ? ALU_SLT :
                  f3 == 3'b011 ? ALU_SLTU :
                  f3 == 3'b100 ? ALU_XOR :
                  f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
                  f3 == 3'b110 ? ALU_OR : ALU_AND;
  always_comb begin
    d_alu = ALU_ADD;
    imm32 = '0;
    d_ill = 1'b0;
    d_wr = 1'b0;
    d_load = 1'b0;
    d_store = 1'b0;
    d_branch = 1'b0;
    d_jump = 1'b0;
    d_src = 1'b1;
    case (op)
      OP_REG: begin
        d_alu = f3_alu;
        d_wr = 1'b1;
        d_src = 1'b0;
        d_ill = f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OP_IMM: begin
        d_alu = f3_alu;
        d_wr = 1'b1;
        imm32 = f3[1:0] == 2'b01 ? {27'b0, i[24:20]} : {{20{i[31]}}, i[31:20]};
        d_ill = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_LOAD: begin
        imm32 = {{20{i[31]}}, i[31:20]};
        d_wr = 1'b1;
        d_load = 1'b1;
        d_ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
        d_store = 1'b1;
        d_ill = f3[2] || f3[1:0] == 2'b11;
      end
      OP_BRANCH: begin
        imm32 = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        d_branch = 1'b1;
        d_src = 1'b0;
        d_ill = f3[2:1] == 2'b01;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {i[31:12], 12'b0};
        d_wr = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        d_wr = 1'b1;
        d_jump = 1'b1;
      end
      OP_JALR: begin
        imm32 = {{20{i[31]}}, i[31:20]};
        d_wr = 1'b1;
        d_jump = 1'b1;
        d_ill = f3 != 3'b000;
      end
      default: d_ill = 1'b1;
    endcase
  end
  assign nop = ILLEGAL_AS_NOP != 0 && d_ill;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pc <= '0;
      bus.alu_funct <= ALU_ADD;
      bus.rs1 <= '0;
      bus.rs2 <= '0;
      bus.rd <= '0;
      bus.immed <= '0;
      bus.alu_src_imm <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.is_load <= 1'b0;
      bus.is_store <= 1'b0;
      bus.is_branch <= 1'b0;
      bus.is_jump <= 1'b0;
      bus.illegal <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_pc <= bus.in_pc;
      bus.alu_funct <= d_alu;
      bus.rs1 <= i[19:15];
      bus.rs2 <= i[24:20];
      bus.rd <= i[11:7];
      bus.immed <= XLEN'($signed(imm32));
      bus.alu_src_imm <= d_src;
      bus.reg_write <= d_wr && i[11:7] != 5'd0 && !nop;
      bus.is_load <= d_load && !nop;
      bus.is_store <= d_store && !nop;
      bus.is_branch <= d_branch && !nop;
      bus.is_jump <= d_jump && !nop;
      bus.illegal <= d_ill;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage with ILLEGAL_AS_NOP=0 (dut0) and =1 (dut1)
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  decode_stage_if b0 ();
  decode_stage_if b1 ();
  decode_stage #(.ILLEGAL_AS_NOP(0)) dut0 (.clk(clk), .rst(rst), .flush(flush), .bus(b0));
  decode_stage #(.ILLEGAL_AS_NOP(1)) dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(b1));
  assign b1.in_valid = b0.in_valid;
  assign b1.in_instr = b0.in_instr;
  assign b1.in_pc = b0.in_pc;
  assign b1.out_ready = b0.out_ready;
  always #5 clk = ~clk;
  localparam logic [63:0] ADD = 0, SRA = 7;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    b0.in_valid = 1'b0;
    b0.in_instr = '0;
    b0.in_pc = '0;
    b0.out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", b0.out_valid, 0);
    chk("rst_alu", b0.alu_funct, ADD);
    chk("rst_immed", b0.immed, 0);
    chk("rst_rd", b0.rd, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    rst = 1'b0;
    b0.in_valid = 1'b1;
    b0.in_instr = 32'hFFF10093;
    b0.in_pc = 32'h100;
    step();
    chk("addi_valid", b0.out_valid, 1);
    chk("addi_rs1", b0.rs1, 2);
    chk("addi_rd", b0.rd, 1);
    chk("addi_imm", b0.immed, 32'hFFFFFFFF);
    chk("addi_alu", b0.alu_funct, ADD);
    chk("addi_src", b0.alu_src_imm, 1);
    chk("addi_wr", b0.reg_write, 1);
    chk("addi_pc", b0.out_pc, 32'h100);
    b0.in_instr = 32'h0051A423;
    b0.in_pc = 32'h104;
    step();
    chk("sw_imm", b0.immed, 8);
    chk("sw_rs1", b0.rs1, 3);
    chk("sw_rs2", b0.rs2, 5);
    chk("sw_store", b0.is_store, 1);
    chk("sw_wr", b0.reg_write, 0);
    chk("sw_pc", b0.out_pc, 32'h104);
    b0.in_instr = 32'h123453B7;
    step();
    chk("lui_valid", b0.out_valid, 1);
    chk("lui_imm", b0.immed, 32'h12345000);
    chk("lui_rd", b0.rd, 7);
    chk("lui_wr", b0.reg_write, 1);
    b0.in_instr = 32'hFE208EE3;
    step();
    chk("beq_imm", b0.immed, 32'hFFFFFFFC);
    chk("beq_branch", b0.is_branch, 1);
    chk("beq_src", b0.alu_src_imm, 0);
    chk("beq_illegal", b0.illegal, 0);
    b0.in_instr = 32'h40325213;
    step();
    chk("srai_alu", b0.alu_funct, SRA);
    chk("srai_imm", b0.immed, 3);
    chk("srai_rd", b0.rd, 4);
    chk("srai_illegal", b0.illegal, 0);
    b0.in_instr = 32'h02208033;
    step();
    chk("addf7_illegal", b0.illegal, 1);
    b0.in_instr = 32'h022080B3;
    step();
    chk("addf7x1_illegal", b0.illegal, 1);
    chk("addf7x1_wr_keep", b0.reg_write, 1);
    chk("addf7x1_wr_nop", b1.reg_write, 0);
    b0.in_instr = 32'h000110E7;
    step();
    chk("jalr_f3_illegal", b0.illegal, 1);
    chk("jalr_f3_jump_keep", b0.is_jump, 1);
    chk("jalr_f3_jump_nop", b1.is_jump, 0);
    b0.in_instr = 32'h0000007F;
    step();
    chk("op7f_illegal", b0.illegal, 1);
    chk("op7f_alu", b0.alu_funct, ADD);
    chk("op7f_illegal_nop", b1.illegal, 1);
    b0.in_valid = 1'b0;
    step();
    chk("consume_valid", b0.out_valid, 0);
    b0.in_valid = 1'b1;
    b0.out_ready = 1'b0;
    b0.in_instr = 32'h00100093;
    step();
    chk("stall_first_rd", b0.rd, 1);
    b0.in_instr = 32'h00200113;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_in_ready", b0.in_ready, 0);
      chk("stall_valid", b0.out_valid, 1);
      chk("stall_rd", b0.rd, 1);
      chk("stall_imm", b0.immed, 1);
    end
    b0.out_ready = 1'b1;
    step();
    chk("release_rd", b0.rd, 2);
    chk("release_imm", b0.immed, 2);
    b0.in_instr = 32'h00300193;
    step();
    chk("next_rd", b0.rd, 3);
    chk("next_valid", b0.out_valid, 1);
    b0.in_valid = 1'b0;
    step();
    chk("drain_valid", b0.out_valid, 0);
    b0.in_valid = 1'b1;
    b0.out_ready = 1'b0;
    b0.in_instr = 32'h00100093;
    step();
    chk("pre_flush_valid", b0.out_valid, 1);
    b0.in_instr = 32'h00400213;
    flush = 1'b1;
    step();
    chk("flush_valid", b0.out_valid, 0);
    flush = 1'b0;
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b1;
    step();
    chk("post_flush_valid", b0.out_valid, 0);
    b0.in_valid = 1'b1;
    b0.in_instr = 32'h00200113;
    step();
    chk("pre_rst_rd", b0.rd, 2);
    b0.in_instr = 32'h00300193;
    rst = 1'b1;
    step();
    chk("rst_mid_valid", b0.out_valid, 0);
    chk("rst_mid_rd", b0.rd, 0);
    chk("rst_mid_imm", b0.immed, 0);
    rst = 1'b0;
    b0.in_valid = 1'b0;
    step();
    chk("post_rst_valid", b0.out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
